// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester ports, the shared read-data return and the
// single-port RAM command bus of mem_port_arbiter.
//
//   r0_* / r1_*   requester 0 (CPU) and requester 1 (DMA/debug):
//                 req, cmd (01 read, 10 write), addr, wdata in;
//                 gnt (acceptance pulse), rvalid (read data pulse) out
//   rdata         read data shared by both requesters
//   mem_cmd       RAM command: 00 idle, 01 read, 10 write
//   mem_addr      RAM address
//   mem_wdata     RAM write data
//   mem_rdata     RAM read data, valid the cycle after mem_cmd=01
//   busy          arbiter is in the middle of a transaction
//
// Modports:
//   master - requesters plus RAM (the environment around the arbiter)
//   slave  - the arbiter itself
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
) ();
    logic          r0_req;
    logic [1:0]    r0_cmd;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;

    logic          r1_req;
    logic [1:0]    r1_cmd;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;

    logic [DW-1:0] rdata;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport master (
        output r0_req, r0_cmd, r0_addr, r0_wdata,
        output r1_req, r1_cmd, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        input  rdata, mem_cmd, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  r0_req, r0_cmd, r0_addr, r0_wdata,
        input  r1_req, r1_cmd, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        output rdata, mem_cmd, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One transaction at a time: IDLE samples requests, ACCESS issues the RAM
// command and the grant pulse, RESP (reads only) returns RAM data with rvalid.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    mem_port_arbiter_if.slave - requester ports, rdata, RAM bus, busy
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t        state;
    logic          last_winner;   // requester that won the previous arbitration
    logic          id_q;          // requester owning the current transaction
    logic [1:0]    cmd_q;         // command of the current transaction
    logic          r0_gnt_q, r1_gnt_q;
    logic          r0_rvalid_q, r1_rvalid_q;
    logic [1:0]    mem_cmd_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata_q;
    logic          busy_q;

    // Requests with a reserved command (00/11) are treated as absent.
    logic valid0, valid1, pick1;
    assign valid0 = bus.r0_req && (bus.r0_cmd == CMD_READ || bus.r0_cmd == CMD_WRITE);
    assign valid1 = bus.r1_req && (bus.r1_cmd == CMD_READ || bus.r1_cmd == CMD_WRITE);
    // r1 wins when it is alone, or on a tie when r0 won last time.
    assign pick1  = valid1 && (!valid0 || !last_winner);

    // NOTE: all state updates below use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            id_q        <= 1'b0;
            cmd_q       <= CMD_NONE;
            r0_gnt_q    <= 1'b0;
            r1_gnt_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            mem_cmd_q   <= CMD_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid0 || valid1) begin
                        state       <= ACCESS;
                        last_winner <= pick1;
                        id_q        <= pick1;
                        cmd_q       <= pick1 ? bus.r1_cmd   : bus.r0_cmd;
                        mem_cmd_q   <= pick1 ? bus.r1_cmd   : bus.r0_cmd;
                        mem_addr_q  <= pick1 ? bus.r1_addr  : bus.r0_addr;
                        mem_wdata_q <= pick1 ? bus.r1_wdata : bus.r0_wdata;
                        r0_gnt_q    <= !pick1;
                        r1_gnt_q    <= pick1;
                        busy_q      <= 1'b1;
                    end
                end
                ACCESS: begin
                    r0_gnt_q  <= 1'b0;
                    r1_gnt_q  <= 1'b0;
                    mem_cmd_q <= CMD_NONE;
                    if (cmd_q == CMD_READ) begin
                        state       <= RESP;
                        r0_rvalid_q <= !id_q;
                        r1_rvalid_q <= id_q;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                RESP: begin
                    // Keep the returned word so rdata holds it after RESP.
                    rdata_q     <= bus.mem_rdata;
                    r0_rvalid_q <= 1'b0;
                    r1_rvalid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The RAM delivers data during RESP itself, so rdata passes it straight
    // through in that cycle and shows the held copy otherwise.
    assign bus.rdata     = (state == RESP) ? bus.mem_rdata : rdata_q;
    assign bus.r0_gnt    = r0_gnt_q;
    assign bus.r1_gnt    = r1_gnt_q;
    assign bus.r0_rvalid = r0_rvalid_q;
    assign bus.r1_rvalid = r1_rvalid_q;
    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives two requesters and a synchronous RAM around mem_port_arbiter and
// compares every cycle against a transaction-level timeline model: each
// acceptance schedules its grant, RAM command, rvalid and busy cycles.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 16;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- requesters ----------------
    typedef struct {
        bit          req;
        bit [1:0]    cmd;
        bit [AW-1:0] addr;
        bit [DW-1:0] wdata;
    } rq_t;

    rq_t rq [2];

    assign bus.r0_req   = rq[0].req;
    assign bus.r0_cmd   = rq[0].cmd;
    assign bus.r0_addr  = rq[0].addr;
    assign bus.r0_wdata = rq[0].wdata;
    assign bus.r1_req   = rq[1].req;
    assign bus.r1_cmd   = rq[1].cmd;
    assign bus.r1_addr  = rq[1].addr;
    assign bus.r1_wdata = rq[1].wdata;

    // ---------------- RAM ----------------
    logic [DW-1:0] ram [1 << AW];

    always @(posedge clk) begin
        if (bus.mem_cmd == 2'b10) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_cmd == 2'b01) bus.mem_rdata <= ram[bus.mem_addr];
    end

    // ---------------- reference model ----------------
    int          e;            // number of clock edges seen
    int          free_edge;    // earliest edge at which a new request may be taken
    bit          last_w;
    bit [DW-1:0] m_ram [1 << AW];
    bit [AW-1:0] m_addr;
    bit [DW-1:0] m_wdata;
    bit [DW-1:0] m_hold;
    bit          acc [2];

    // Expected values for the interval following each edge.
    bit          s_gnt  [2][MAXC];
    bit          s_rv   [2][MAXC];
    bit [1:0]    s_cmd  [MAXC];
    bit [DW-1:0] s_data [MAXC];
    bit          s_busy [MAXC];

    int n_checks = 0;
    int n_errors = 0;
    int wait_tx [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic bit is_valid(input rq_t r);
        return r.req && (r.cmd == 2'b01 || r.cmd == 2'b10);
    endfunction

    task automatic model_edge();
        bit v0, v1;
        int w;
        e++;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (e + 3 >= MAXC) begin
            $display("FAIL model_capacity: got edge %0d expected below %0d", e, MAXC - 3);
            $fatal(1, "model timeline exhausted");
        end
        if (reset) begin
            last_w    = 1'b1;
            free_edge = e + 1;
            m_addr    = '0;
            m_wdata   = '0;
            m_hold    = '0;
            for (int k = e; k <= e + 2; k++) begin
                s_gnt[0][k] = 1'b0; s_gnt[1][k] = 1'b0;
                s_rv[0][k]  = 1'b0; s_rv[1][k]  = 1'b0;
                s_cmd[k]    = 2'b00; s_busy[k]  = 1'b0;
            end
        end else if (e >= free_edge) begin
            v0 = is_valid(rq[0]);
            v1 = is_valid(rq[1]);
            if (v0 || v1) begin
                w        = (v0 && v1) ? int'(!last_w) : (v1 ? 1 : 0);
                last_w   = (w == 1);
                acc[w]   = 1'b1;
                s_gnt[w][e] = 1'b1;
                s_cmd[e]    = rq[w].cmd;
                s_busy[e]   = 1'b1;
                m_addr      = rq[w].addr;
                m_wdata     = rq[w].wdata;
                if (rq[w].cmd == 2'b10) begin
                    m_ram[rq[w].addr] = rq[w].wdata;
                    free_edge = e + 2;
                end else begin
                    s_rv[w][e+1] = 1'b1;
                    s_data[e+1]  = m_ram[rq[w].addr];
                    s_busy[e+1]  = 1'b1;
                    free_edge    = e + 3;
                end
            end
        end
        if (s_rv[0][e] || s_rv[1][e]) m_hold = s_data[e];
    endtask

    task automatic check_outputs();
        check("r0_gnt",    bus.r0_gnt,    s_gnt[0][e]);
        check("r1_gnt",    bus.r1_gnt,    s_gnt[1][e]);
        check("r0_rvalid", bus.r0_rvalid, s_rv[0][e]);
        check("r1_rvalid", bus.r1_rvalid, s_rv[1][e]);
        check("rdata",     bus.rdata,     m_hold);
        check("mem_cmd",   bus.mem_cmd,   s_cmd[e]);
        check("mem_addr",  bus.mem_addr,  m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
        check("busy",      bus.busy,      s_busy[e]);
        // A waiting requester may see the other side win at most once.
        if (reset) begin
            wait_tx[0] = 0;
            wait_tx[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if ((i == 0 ? bus.r1_gnt : bus.r0_gnt) && is_valid(rq[i])) wait_tx[i]++;
                if (i == 0 ? bus.r0_gnt : bus.r1_gnt) begin
                    check($sformatf("starve_r%0d", i), (wait_tx[i] > 1) ? 32'd1 : 32'd0, 32'd0);
                    wait_tx[i] = 0;
                end
            end
        end
    endtask

    // One clock: model reacts to the edge, outputs checked at the falling
    // edge, and granted requesters drop their request.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 2; i++) if (acc[i]) rq[i].req = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_rq(input int i, input bit [1:0] cmd, input bit [AW-1:0] addr,
                          input bit [DW-1:0] wdata);
        rq[i].req   = 1'b1;
        rq[i].cmd   = cmd;
        rq[i].addr  = addr;
        rq[i].wdata = wdata;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
    endtask

    initial begin
        bit [DW-1:0] v;
        e         = 0;
        free_edge = 0;
        last_w    = 1'b1;
        m_addr    = '0;
        m_wdata   = '0;
        m_hold    = '0;
        wait_tx[0] = 0;
        wait_tx[1] = 0;
        bus.mem_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            v        = DW'(i * 16'h0101) ^ 16'h5A5A;
            ram[i]   = v;
            m_ram[i] = v;
        end
        ram[5]   = 16'hBEEF;
        m_ram[5] = 16'hBEEF;
        rq[0] = '{req: 1'b0, cmd: 2'b00, addr: '0, wdata: '0};
        rq[1] = '{req: 1'b0, cmd: 2'b00, addr: '0, wdata: '0};
        reset = 1'b1;

        // Reset state, with a stray request present that must be ignored.
        set_rq(0, 2'b01, 9'h003, 16'h0);
        do_reset(3);
        rq[0].req = 1'b0;
        run(2);

        // Single read of 0x005 by r0.
        set_rq(0, 2'b01, 9'h005, 16'h0);
        run(5);

        // Single write by r1 to the top address.
        set_rq(1, 2'b10, 9'h1FF, 16'h1234);
        run(4);

        // Reserved command is ignored.
        set_rq(0, 2'b11, 9'h011, 16'hAAAA);
        run(4);
        rq[0].req = 1'b0;

        // Contention after reset: both read continuously.
        do_reset(1);
        for (int t = 0; t < 14; t++) begin
            if (!rq[0].req) set_rq(0, 2'b01, 9'(t), 16'h0);
            if (!rq[1].req) set_rq(1, 2'b01, 9'(t + 32), 16'h0);
            cycle();
        end
        rq[0].req = 1'b0;
        rq[1].req = 1'b0;
        run(3);

        // Reset during the ACCESS cycle of an r1 read, then a tie.
        set_rq(1, 2'b01, 9'h007, 16'h0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_rq(0, 2'b01, 9'h008, 16'h0);
        set_rq(1, 2'b10, 9'h009, 16'hC0DE);
        run(6);

        // r1 raises its request during r0's RESP cycle.
        set_rq(0, 2'b01, 9'h009, 16'h0);
        run(2);
        set_rq(1, 2'b01, 9'h005, 16'h0);
        run(5);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (rq[i].req && !is_valid(rq[i])) rq[i].req = 1'b0;
                else if (!rq[i].req && $urandom_range(0, 2) == 0)
                    set_rq(i, 2'($urandom_range(0, 3)),
                           ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15)),
                           16'($urandom));
            end
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        rq[0].req = 1'b0;
        rq[1].req = 1'b0;
        run(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, 9, address width.
REQ-002 Parameter: DW, 16, data width.
REQ-003 The block SHALL use clock clk and reset reset; reset is synchronous, active-high.
REQ-004 Ports SHALL be exactly:
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 r0_req  in  1  requester 0 (CPU) access request
 r0_cmd  in  2  01=read, 10=write
 r0_addr  in  AW  requester 0 address
 r0_wdata  in  DW  requester 0 write data
 r0_gnt  out  1  requester 0 request accepted (1-cycle pulse)
 r0_rvalid  out  1  requester 0 read data valid (1-cycle pulse)
 r1_req, r1_cmd, r1_addr, r1_wdata, r1_gnt, r1_rvalid  same widths/meaning for requester 1 (DMA/debug)
 rdata  out  DW  read data, shared by both requesters
 mem_cmd  out  2  RAM command: 00 idle, 01 read, 10 write
 mem_addr  out  AW  RAM address
 mem_wdata  out  DW  RAM write data
 mem_rdata  in  DW  RAM read data, valid the cycle after mem_cmd=01
 busy  out  1  high in any state other than IDLE

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-006 A request is valid only when rX_req=1 and rX_cmd is 01 or 10; req with cmd 00/11 SHALL be ignored (no gnt, no RAM access).
REQ-007 In IDLE with at least one valid request, at the clock edge the block SHALL latch the winner's cmd, addr, wdata and id, update last_winner, and enter ACCESS.
REQ-008 Arbitration SHALL be round-robin: a single valid requester wins; if both are valid, the requester that is not last_winner wins.
REQ-009 In ACCESS the block SHALL drive mem_cmd/mem_addr/mem_wdata from the latched values and pulse the winner's rX_gnt for exactly that cycle.
REQ-010 From ACCESS, a write SHALL go to IDLE; a read SHALL go to RESP.
REQ-011 In RESP the block SHALL drive rdata=mem_rdata, pulse the winner's rX_rvalid for that cycle, drive mem_cmd=00, and return to IDLE.
REQ-012 rdata SHALL hold its last value outside RESP.
REQ-013 Outside ACCESS, mem_cmd SHALL be 00; mem_addr and mem_wdata SHALL hold the latched values.
REQ-014 Requests are sampled only in IDLE; requests raised in ACCESS/RESP SHALL wait, and requesters SHALL hold req/cmd/addr/wdata stable until gnt.
REQ-015 Timing SHALL be: request seen at edge N leads to gnt in cycle N+1, and for reads rvalid in cycle N+2; the next acceptance is no earlier than edge N+2 for writes and N+3 for reads.
REQ-016 At most one of r0_gnt/r1_gnt and at most one of r0_rvalid/r1_rvalid SHALL be high in any cycle.
REQ-017 A requester that holds req continuously SHALL receive gnt within two transactions (no starvation).

Reset
REQ-018 While reset=1 at an edge, the block SHALL set state=IDLE, all gnt/rvalid=0, mem_cmd=00, mem_addr=0, mem_wdata=0, rdata=0, busy=0, and last_winner=1 (so r0 wins the first tie).
REQ-019 Reset asserted mid-transaction SHALL abort it: no gnt or rvalid is issued for the aborted access after the reset edge.
REQ-020 Requests present while reset=1 SHALL be ignored; arbitration resumes on the first edge with reset=0.

Verification
REQ-021 Single read: r0 reads addr 0x005 with RAM[5]=0xBEEF -> r0_gnt and mem_cmd=01/mem_addr=0x005 next cycle, then r0_rvalid=1 with rdata=0xBEEF; r1 signals stay 0.
REQ-022 Single write: r1 writes 0x1234 to 0x1FF -> one cycle with mem_cmd=10, mem_addr=0x1FF, mem_wdata=0x1234, r1_gnt=1; no rvalid; busy low the following cycle.
REQ-023 Contention after reset: both request reads continuously -> grant order r0, r1, r0, r1; each rvalid goes to the granted requester 2 cycles after its acceptance edge.
REQ-024 Invalid command: r0_req=1 with cmd=11 -> no gnt, mem_cmd stays 00, busy stays 0.
REQ-025 Reset mid-read: reset in the ACCESS cycle of an r1 read -> no r1_rvalid, all outputs at reset values the next cycle, and the next tie grants r0.
REQ-026 Late request: r1 raises req during r0's RESP -> r1 accepted at the first IDLE edge, r1_gnt one cycle later; r0's rvalid is not affected.
